// File: rtl/audio_pkg.sv
// rtl/audio_pkg.sv - shared audio widths, limits, FSM states and saturating helpers
// Purpose : common definitions for the peak detector, history-RAM writer and display reader.
// Contents: SAMPLE_W (input sample width), PEAK_W (display-unit width), MAX_PEAK (top of
//           the display scale), FSM state constants, max_u / sat_sub helpers.
package audio_pkg;

  localparam int SAMPLE_W = 16;
  localparam int PEAK_W   = 9;
  localparam int MAX_PEAK = 271;

  typedef logic [0:0] state_t;
  localparam state_t ST_ACCUM = 1'b0;
  localparam state_t ST_DECAY = 1'b1;

  function automatic logic [PEAK_W-1:0] max_u(input logic [PEAK_W-1:0] a,
                                               input logic [PEAK_W-1:0] b);
    return (a > b) ? a : b;
  endfunction

  // Subtract with a floor of zero; display levels never wrap below silence.
  function automatic logic [PEAK_W-1:0] sat_sub(input logic [PEAK_W-1:0] a,
                                                 input logic [PEAK_W-1:0] b);
    return (a > b) ? (a - b) : '0;
  endfunction

endpackage

// File: rtl/abs_scale.sv
// rtl/abs_scale.sv - stage 1: magnitude, saturate, shift to display units, clamp, clip detect
// Purpose : converts a signed sample into a registered display-unit level.
// Ports   : clk, rst          - clock, synchronous active-high reset
//           sample            - signed two's-complement input sample
//           sample_valid      - qualifies sample
//           s1, s1_valid      - registered level (0..MAX_PEAK) and its strobe
//           clip_hit          - combinational: the sample now in stage 1 is at full scale
module abs_scale
  import audio_pkg::*;
#(
  parameter int SHIFT = 6
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [SAMPLE_W-1:0] sample,
  input  logic                sample_valid,
  output logic [PEAK_W-1:0]   s1,
  output logic                s1_valid,
  output logic                clip_hit
);

  localparam logic [SAMPLE_W-1:0] FULL_SCALE = {1'b0, {(SAMPLE_W-1){1'b1}}};
  localparam logic [SAMPLE_W-1:0] MOST_NEG   = {1'b1, {(SAMPLE_W-1){1'b0}}};
  localparam logic [SAMPLE_W-1:0] MAX_WIDE   = SAMPLE_W'(MAX_PEAK);

  logic [SAMPLE_W-1:0] mag;
  logic [SAMPLE_W-1:0] shifted;
  logic [PEAK_W-1:0]   scaled;

  logic [PEAK_W-1:0]   s1_q, s1_d;
  logic                s1_valid_q, s1_valid_d;

  always_comb begin
    mag = sample;
    // The most negative code has no positive twin; pin it to full scale.
    if (sample == MOST_NEG) begin
      mag = FULL_SCALE;
    end else if (sample[SAMPLE_W-1]) begin
      mag = ~sample + 1'b1;
    end

    shifted = mag >> SHIFT;
    scaled  = (shifted > MAX_WIDE) ? PEAK_W'(MAX_PEAK) : shifted[PEAK_W-1:0];

    clip_hit = sample_valid && (mag >= FULL_SCALE);
  end

  always_comb begin
    s1_d       = sample_valid ? scaled : s1_q;
    s1_valid_d = sample_valid;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q       <= '0;
      s1_valid_q <= 1'b0;
    end else begin
      s1_q       <= s1_d;
      s1_valid_q <= s1_valid_d;
    end
  end

  assign s1       = s1_q;
  assign s1_valid = s1_valid_q;

endmodule

// File: rtl/peak_detect.sv
// rtl/peak_detect.sv - audio peak meter with decaying hold, window max capture and clip flag
// Purpose : tracks a decaying peak-hold level and a per-capture window maximum; on each
//           writer request it captures the larger of the two for the history RAM.
// Ports   : clk, rst          - clock, synchronous active-high reset
//           sample            - signed audio sample; sample_valid qualifies it
//           frame_tick        - end-of-frame strobe, triggers one decay step
//           wr_en             - capture request from the history-RAM writer
//           peak, peak_valid  - captured level (held) and its one-cycle strobe
//           clip              - sticky overload flag for the current capture window
module peak_detect
  import audio_pkg::*;
#(
  parameter int DECAY = 4,
  parameter int SHIFT = 6
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [SAMPLE_W-1:0] sample,
  input  logic                sample_valid,
  input  logic                frame_tick,
  input  logic                wr_en,
  output logic [PEAK_W-1:0]   peak,
  output logic                peak_valid,
  output logic                clip
);

  localparam logic [PEAK_W-1:0] DECAY_U = PEAK_W'(DECAY);

  logic [PEAK_W-1:0] s1;
  logic              s1_valid;
  logic              clip_hit;

  state_t            state_q, state_d;
  logic [PEAK_W-1:0] hold_q, hold_d;
  logic [PEAK_W-1:0] win_max_q, win_max_d;
  logic [PEAK_W-1:0] peak_q, peak_d;
  logic              peak_valid_q, peak_valid_d;
  logic              clip_q, clip_d;

  logic              decay_en;
  logic [PEAK_W-1:0] hold_upd;

  abs_scale #(
    .SHIFT(SHIFT)
  ) u_abs (
    .clk         (clk),
    .rst         (rst),
    .sample      (sample),
    .sample_valid(sample_valid),
    .s1          (s1),
    .s1_valid    (s1_valid),
    .clip_hit    (clip_hit)
  );

  // A tick landing in the one-cycle DECAY state is swallowed so back-to-back
  // ticks cannot double-decay the hold.
  always_comb begin
    decay_en = frame_tick && (state_q == ST_ACCUM);
    state_d  = ST_ACCUM;
    if (state_q == ST_ACCUM && frame_tick) begin
      state_d = ST_DECAY;
    end
  end

  // Hold: fold in the stage-2 sample first, then decay the result.
  always_comb begin
    hold_upd = s1_valid ? max_u(hold_q, s1) : hold_q;
    hold_d   = decay_en ? sat_sub(hold_upd, DECAY_U) : hold_upd;
  end

  // Capture reads pre-edge hold/win_max; the window restarts with any sample
  // arriving on the capture cycle so it is not lost from the next window.
  always_comb begin
    peak_d       = wr_en ? max_u(hold_q, win_max_q) : peak_q;
    peak_valid_d = wr_en;
    if (wr_en) begin
      win_max_d = s1_valid ? s1 : '0;
    end else begin
      win_max_d = s1_valid ? max_u(win_max_q, s1) : win_max_q;
    end
  end

  always_comb begin
    clip_d = wr_en ? clip_hit : (clip_q | clip_hit);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_ACCUM;
      hold_q       <= '0;
      win_max_q    <= '0;
      peak_q       <= '0;
      peak_valid_q <= 1'b0;
      clip_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      hold_q       <= hold_d;
      win_max_q    <= win_max_d;
      peak_q       <= peak_d;
      peak_valid_q <= peak_valid_d;
      clip_q       <= clip_d;
    end
  end

  assign peak       = peak_q;
  assign peak_valid = peak_valid_q;
  assign clip       = clip_q;

endmodule

// File: tb/tb_peak_detect.sv
// tb/tb_peak_detect.sv - self-checking bench for peak_detect against a behavioural model
module tb_peak_detect;

  localparam int DEC = 4;
  localparam int SH  = 6;
  localparam int MAXP = 271;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] sample = '0;
  logic        sample_valid = 1'b0;
  logic        frame_tick = 1'b0;
  logic        wr_en = 1'b0;
  logic [8:0]  peak;
  logic        peak_valid;
  logic        clip;

  int checks = 0;
  int errors = 0;

  // Behavioural model state
  int  m_s1 = 0;
  bit  m_s1v = 0;
  int  m_hold = 0;
  int  m_win = 0;
  int  m_peak = 0;
  bit  m_pv = 0;
  bit  m_clip = 0;
  bit  m_in_decay = 0;

  peak_detect #(.DECAY(DEC), .SHIFT(SH)) dut (
    .clk         (clk),
    .rst         (rst),
    .sample      (sample),
    .sample_valid(sample_valid),
    .frame_tick  (frame_tick),
    .wr_en       (wr_en),
    .peak        (peak),
    .peak_valid  (peak_valid),
    .clip        (clip)
  );

  always #5 clk = ~clk;

  function automatic int imax(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Advance the model by one clock edge using the inputs now applied.
  task automatic model_edge();
    int v, mag, lvl, h, n_win, n_hold;
    bit hit, dec_ok;
    v   = int'($signed(sample));
    mag = (v < 0) ? -v : v;
    if (mag > 32767) mag = 32767;
    lvl = mag / (1 << SH);
    if (lvl > MAXP) lvl = MAXP;
    hit = sample_valid && (mag >= 32767);
    dec_ok = frame_tick && !m_in_decay;

    h = m_s1v ? imax(m_hold, m_s1) : m_hold;
    n_hold = dec_ok ? imax(h - DEC, 0) : h;
    if (wr_en) n_win = m_s1v ? m_s1 : 0;
    else       n_win = m_s1v ? imax(m_win, m_s1) : m_win;

    if (rst) begin
      m_s1 = 0; m_s1v = 0; m_hold = 0; m_win = 0;
      m_peak = 0; m_pv = 0; m_clip = 0; m_in_decay = 0;
    end else begin
      if (wr_en) m_peak = imax(m_hold, m_win);
      m_pv   = wr_en;
      m_clip = wr_en ? hit : (m_clip | hit);
      m_hold = n_hold;
      m_win  = n_win;
      m_in_decay = dec_ok;
      if (sample_valid) m_s1 = lvl;
      m_s1v = sample_valid;
    end
  endtask

  task automatic step(input bit r, input bit sv, input int s, input bit ft, input bit we);
    @(negedge clk);
    rst = r; sample_valid = sv; sample = 16'(s); frame_tick = ft; wr_en = we;
    @(posedge clk);
    model_edge();
    #1;
    chk("peak",       int'(peak),            m_peak);
    chk("peak_valid", int'(peak_valid),      int'(m_pv));
    chk("clip",       int'(clip),            int'(m_clip));
    chk("hold",       int'(dut.hold_q),      m_hold);
    chk("win_max",    int'(dut.win_max_q),   m_win);
    chk("fsm",        int'(dut.state_q),     int'(m_in_decay));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0);
  endtask

  task automatic do_reset();
    step(1, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0);
  endtask

  initial begin
    // Reset state
    do_reset();
    chk("rst_peak", int'(peak), 0);
    chk("rst_clip", int'(clip), 0);

    // Single sample and capture
    step(0, 1, 12800, 0, 0);
    idle(1);
    chk("single_hold", int'(dut.hold_q), 200);
    step(0, 0, 0, 0, 1);
    chk("single_peak", int'(peak), 200);
    chk("single_pv", int'(peak_valid), 1);
    idle(1);
    chk("single_pv_drop", int'(peak_valid), 0);

    // Decay floor
    do_reset();
    step(0, 1, 384, 0, 0);
    idle(1);
    chk("floor_hold6", int'(dut.hold_q), 6);
    step(0, 0, 0, 1, 0);
    chk("floor_hold2", int'(dut.hold_q), 2);
    idle(1);
    step(0, 0, 0, 1, 0);
    chk("floor_hold0", int'(dut.hold_q), 0);
    idle(1);
    step(0, 0, 0, 1, 0);
    chk("floor_stay0", int'(dut.hold_q), 0);

    // Saturation of the most negative code
    do_reset();
    step(0, 1, -32768, 0, 0);
    chk("sat_clip", int'(clip), 1);
    idle(1);
    chk("sat_win", int'(dut.win_max_q), 271);
    step(0, 0, 0, 0, 1);
    chk("sat_peak", int'(peak), 271);
    chk("sat_clip_clr", int'(clip), 0);
    step(0, 1, 32767, 0, 1);
    chk("clip_on_capture", int'(clip), 1);

    // Coincident capture, decay and stage-2 sample
    do_reset();
    step(0, 1, 6400, 0, 0);
    idle(1);
    step(0, 0, 0, 0, 1);
    step(0, 1, 9600, 0, 0);
    step(0, 0, 0, 1, 1);
    chk("coin_peak", int'(peak), 100);
    chk("coin_hold", int'(dut.hold_q), 146);
    chk("coin_win", int'(dut.win_max_q), 150);

    // Reset while a sample sits in stage 1
    do_reset();
    step(0, 1, 32000, 0, 0);
    step(1, 0, 0, 0, 0);
    idle(3);
    chk("mid_rst_hold", int'(dut.hold_q), 0);
    chk("mid_rst_peak", int'(peak), 0);

    // Consecutive frame ticks
    do_reset();
    step(0, 1, 12800, 0, 0);
    idle(1);
    step(0, 0, 0, 1, 0);
    chk("fsm_decay", int'(dut.state_q), 1);
    step(0, 0, 0, 1, 0);
    chk("fsm_back", int'(dut.state_q), 0);
    chk("fsm_hold", int'(dut.hold_q), 196);

    // Randomised traffic
    for (int i = 0; i < 600; i++) begin
      int s;
      case ($urandom_range(0, 9))
        0:       s = -32768;
        1:       s = 32767;
        2:       s = -32767;
        default: s = int'($urandom_range(0, 65535)) - 32768;
      endcase
      step(($urandom_range(0, 63) == 0), $urandom_range(0, 1) == 1, s,
           $urandom_range(0, 7) == 0, $urandom_range(0, 5) == 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
